sprite_compositor: RTL

- Parametrised, pipelined pixel compositor between the VGA timing generator and the colour output register.
- Generalises the fixed four-ghost/one-Pac-Man display path to NSPR sprites, each with an enable, an orientation mode, a transparency colour key and a shadow position.
- Sprite state is double-buffered at frame boundaries so positions never tear mid-frame.
- Also carries the game-over overlay window and a pixel-valid pipeline.

---
 rtl/pacman_disp_pkg.sv | 27 ++
 rtl/sprite_hit_unit.sv | 63 ++++++
 rtl/sprite_compositor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pacman_disp_pkg.sv
// Shared constants and types for the Pac-Man display path: orientation modes,
// palette colours, per-pixel flag bundle and the sprite ROM address width helper.
package pacman_disp_pkg;

  localparam logic [1:0] ROT_NORM  = 2'd0;
  localparam logic [1:0] ROT_MIRX  = 2'd1;
  localparam logic [1:0] ROT_XPOS  = 2'd2;
  localparam logic [1:0] ROT_XPOSF = 2'd3;

  localparam logic [11:0] CLR_KEY  = 12'h000;
  localparam logic [11:0] CLR_WALL = 12'hFFF;
  localparam logic [11:0] CLR_BEAN = 12'hFF0;
  localparam logic [11:0] CLR_BG   = 12'h000;

  // Per-pixel side information that rides the pipeline next to the sprite hits.
  typedef struct packed {
    logic ovl_hit;
    logic wall;
    logic bean;
    logic over;
  } pix_flags_t;

  function automatic int spr_aw(input int size);
    return $clog2(size * size);
  endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// One sprite lane: window compare against the shadow position and the
// orientation-mapped ROM address, both registered in stage 1.
module sprite_hit_unit
  import pacman_disp_pkg::*;
#(
  parameter int SPR_SIZE = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    col,
  input  logic [8:0]                    row,
  input  logic [9:0]                    x,
  input  logic [8:0]                    y,
  input  logic                          en,
  input  logic [1:0]                    rot,
  output logic                          hit,
  output logic [spr_aw(SPR_SIZE)-1:0]   addr
);

  localparam int LW = $clog2(SPR_SIZE);
  localparam int AW = spr_aw(SPR_SIZE);
  localparam logic [10:0] SZ = 11'(SPR_SIZE);

  logic [10:0]   c11, r11, x11, y11;
  logic          hit_c;
  logic [LW-1:0] dxl, dyl;
  logic [AW-1:0] addr_c;

  // 11-bit compare so a sprite near the right/bottom edge never wraps to 0.
  assign c11 = {1'b0, col};
  assign r11 = {2'b00, row};
  assign x11 = {1'b0, x};
  assign y11 = {2'b00, y};

  assign hit_c = en && (c11 >= x11) && (c11 < x11 + SZ) &&
                 (r11 >= y11) && (r11 < y11 + SZ);

  // Only the low bits of the offset matter once the pixel is inside the window.
  assign dxl = col[LW-1:0] - x[LW-1:0];
  assign dyl = row[LW-1:0] - y[LW-1:0];

  always_comb begin
    addr_c = {dyl, dxl};
    case (rot)
      ROT_NORM:  addr_c = {dyl, dxl};
      ROT_MIRX:  addr_c = {dyl, ~dxl};
      ROT_XPOS:  addr_c = {dxl, dyl};
      ROT_XPOSF: addr_c = {dxl, ~dyl};
      default:   addr_c = {dyl, dxl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit  <= 1'b0;
      addr <= '0;
    end else begin
      hit <= hit_c;
      if (hit_c) addr <= addr_c;
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: sprite/overlay addressing, ROM wait, priority
// mux. Sprite and game-over state are shadowed at frame_start to avoid tearing.
module sprite_compositor
  import pacman_disp_pkg::*;
#(
  parameter int          NSPR       = 5,
  parameter int          SPR_SIZE   = 32,
  parameter logic [11:0] COLOR_KEY  = CLR_KEY,
  parameter logic [11:0] WALL_COLOR = CLR_WALL,
  parameter logic [11:0] BEAN_COLOR = CLR_BEAN,
  parameter logic [11:0] BG_COLOR   = CLR_BG,
  parameter int          OVL_X0     = 180,
  parameter int          OVL_Y0     = 100,
  parameter int          OVL_W      = 320,
  parameter int          OVL_H      = 190
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  input  logic                               pix_valid_in,
  input  logic [9:0]                         col_in,
  input  logic [8:0]                         row_in,
  input  logic                               wall_in,
  input  logic                               bean_in,
  input  logic                               over_in,
  input  logic [NSPR*10-1:0]                 spr_x,
  input  logic [NSPR*9-1:0]                  spr_y,
  input  logic [NSPR-1:0]                    spr_en,
  input  logic [NSPR*2-1:0]                  spr_rot,
  output logic [NSPR*spr_aw(SPR_SIZE)-1:0]   spr_addr,
  input  logic [NSPR*12-1:0]                 spr_color,
  output logic [$clog2(OVL_W*OVL_H)-1:0]     ovl_addr,
  input  logic [11:0]                        ovl_color,
  output logic                               pix_valid_out,
  output logic [11:0]                        rgb_out
);

  localparam int STAGES = 3;
  localparam int AW     = spr_aw(SPR_SIZE);
  localparam int OAW    = $clog2(OVL_W*OVL_H);
  localparam logic [10:0] OX0 = 11'(OVL_X0);
  localparam logic [10:0] OX1 = 11'(OVL_X0 + OVL_W);
  localparam logic [10:0] OY0 = 11'(OVL_Y0);
  localparam logic [10:0] OY1 = 11'(OVL_Y0 + OVL_H);

  logic [NSPR-1:0][9:0]    sh_x;
  logic [NSPR-1:0][8:0]    sh_y;
  logic [NSPR-1:0]         sh_en;
  logic [NSPR-1:0][1:0]    sh_rot;
  logic                    sh_over;

  logic [STAGES:1]         vld_pipe;
  pix_flags_t              flg1, flg2;
  logic [NSPR-1:0]         hit1, hit2;
  logic [NSPR-1:0][AW-1:0] addr_arr;
  logic [NSPR-1:0][11:0]   spr_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x    <= '0;
      sh_y    <= '0;
      sh_en   <= '0;
      sh_rot  <= '0;
      sh_over <= 1'b0;
    end else if (frame_start) begin
      sh_x    <= spr_x;
      sh_y    <= spr_y;
      sh_en   <= spr_en;
      sh_rot  <= spr_rot;
      sh_over <= over_in;
    end
  end

  for (genvar i = 0; i < NSPR; i++) begin : g_spr
    sprite_hit_unit #(.SPR_SIZE(SPR_SIZE)) u_hit (
      .clk  (clk),
      .rst  (rst),
      .col  (col_in),
      .row  (row_in),
      .x    (sh_x[i]),
      .y    (sh_y[i]),
      .en   (sh_en[i]),
      .rot  (sh_rot[i]),
      .hit  (hit1[i]),
      .addr (addr_arr[i])
    );
  end

  assign spr_addr = addr_arr;
  assign spr_pix  = spr_color;

  // Overlay window decode, sharing stage 1 with the sprite lanes.
  logic [10:0]    c11, r11;
  logic           ovl_hit_c;
  logic [OAW-1:0] ovl_addr_c;

  assign c11        = {1'b0, col_in};
  assign r11        = {2'b00, row_in};
  assign ovl_hit_c  = (c11 >= OX0) && (c11 < OX1) && (r11 >= OY0) && (r11 < OY1);
  assign ovl_addr_c = OAW'(r11 - OY0) * OAW'(OVL_W) + OAW'(c11 - OX0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      flg1     <= '0;
      flg2     <= '0;
      hit2     <= '0;
      ovl_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid_in};
      flg1     <= '{ovl_hit: ovl_hit_c, wall: wall_in, bean: bean_in, over: sh_over};
      flg2     <= flg1;
      hit2     <= hit1;
      if (ovl_hit_c) ovl_addr <= ovl_addr_c;
    end
  end

  logic [11:0] pix_c;
  logic [11:0] spr_sel;
  logic        spr_found;

  always_comb begin
    spr_found = 1'b0;
    spr_sel   = BG_COLOR;
    for (int i = 0; i < NSPR; i++) begin
      if (!spr_found && hit2[i] && spr_pix[i] != COLOR_KEY) begin
        spr_found = 1'b1;
        spr_sel   = spr_pix[i];
      end
    end
    pix_c = BG_COLOR;
    if (flg2.over)      pix_c = flg2.ovl_hit ? ovl_color : BG_COLOR;
    else if (flg2.wall) pix_c = WALL_COLOR;
    else if (spr_found) pix_c = spr_sel;
    else if (flg2.bean) pix_c = BEAN_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_out <= '0;
    else     rgb_out <= vld_pipe[STAGES-1] ? pix_c : 12'h000;
  end

  assign pix_valid_out = vld_pipe[STAGES];

endmodule
